// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a byte over valid/ready and sends it as
// start + data + optional parity + stop bits with a registered, idle-high line.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cyc_cnt, cyc_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic                 par, par_n;
    logic                 tx_n, done_n, bit_end;

    assign tx_ready = (state == IDLE) && !rst;
    assign bit_end  = (cyc_cnt == CYC_LAST);

    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        par_n   = par;
        done_n  = 1'b0;
        if (state != IDLE)
            cyc_n = bit_end ? '0 : cyc_cnt + 1'b1;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = START;
                cyc_n   = '0;
                bit_n   = '0;
                sh_n    = tx_data[DATA_BITS-1:0];
                par_n   = (^tx_data[DATA_BITS-1:0]) ^ (PARITY_ODD != 0);
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                // The outgoing bit always sits at the shift register's send end.
                if (MSB_FIRST != 0) sh_n = {shreg[DATA_BITS-2:0], 1'b0};
                else                sh_n = {1'b0, shreg[DATA_BITS-1:1]};
                if (bit_cnt == DATA_LAST) begin
                    bit_n   = '0;
                    state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    bit_n = bit_cnt + 1'b1;
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP: if (bit_end) begin
                // bit_cnt is reused to count stop bits.
                if (bit_cnt == STOP_LAST) begin
                    bit_n   = '0;
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    bit_n = bit_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Line level follows the next state so tx changes on the same edge.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = (MSB_FIRST != 0) ? sh_n[DATA_BITS-1] : sh_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cyc_cnt <= cyc_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            par     <= par_n;
            tx      <= tx_n;
            tx_busy <= (state_n != IDLE);
            tx_done <= done_n;
        end
    end
endmodule
